// File: rtl/array_alloc_arbiter_pkg.sv
// Shared encodings and default sizing for the heap array allocator arbiter.
package array_alloc_pkg;

    typedef enum logic {
        OP_ALLOC = 1'b0,
        OP_FREE  = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        ERR_OK        = 2'd0,
        ERR_EXHAUSTED = 2'd1,
        ERR_BADFREE   = 2'd2
    } rsp_err_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RESP  = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    localparam int DefNReq               = 2;
    localparam int DefNArrays            = 4;
    localparam int DefMemoryElementWidth = 12;

endpackage

// File: rtl/array_alloc_arbiter_if.sv
// Request/response bus between the requesters and the allocator arbiter.
interface array_alloc_arbiter_if #(
    parameter int NReq               = 2,
    parameter int MemoryElementWidth = 12
);
    localparam int IdW = (NReq > 1) ? $clog2(NReq) : 1;

    logic [NReq-1:0]                    req_valid;
    logic [NReq-1:0]                    req_op;
    logic [NReq*MemoryElementWidth-1:0] req_array;
    logic [NReq-1:0]                    req_ready;
    logic                               rsp_valid;
    logic                               rsp_ready;
    logic [IdW-1:0]                     rsp_id;
    logic [MemoryElementWidth-1:0]      rsp_array;
    logic [1:0]                         rsp_error;

    modport master (
        output req_valid, req_op, req_array, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_array, rsp_error
    );

    modport slave (
        input  req_valid, req_op, req_array, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_array, rsp_error
    );

endinterface

// File: rtl/array_alloc_arbiter_rr.sv
// Round-robin arbiter: one-hot grant, priority moves past the winner on advance.
module rr_arbiter #(
    parameter int NReq = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [NReq-1:0] req,
    input  logic            advance,
    output logic [NReq-1:0] grant
);
    localparam int PtrW = (NReq > 1) ? $clog2(NReq) : 1;
    localparam logic [PtrW:0]   NReqW = (PtrW+1)'(NReq);
    localparam logic [PtrW-1:0] Last  = PtrW'(NReq - 1);

    logic [PtrW-1:0] ptr_q, ptr_d, win;
    logic [PtrW:0]   idx;
    logic            found;

    always_comb begin
        grant = '0;
        win   = '0;
        found = 1'b0;
        idx   = '0;
        // Scan from the pointer upward, wrapping modulo NReq.
        for (int off = 0; off < NReq; off++) begin
            idx = {1'b0, ptr_q} + (PtrW+1)'(off);
            if (idx >= NReqW) idx = idx - NReqW;
            if (!found && req[idx[PtrW-1:0]]) begin
                found                 = 1'b1;
                grant[idx[PtrW-1:0]] = 1'b1;
                win                   = idx[PtrW-1:0];
            end
        end
        ptr_d = (win == Last) ? '0 : win + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q <= '0;
        end else if (advance && found) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/array_alloc_arbiter.sv
// Arbitrates alloc/free requests onto a bump + LIFO free-stack heap allocator,
// with a flush sequence that zeroes every issued array's size.
module array_alloc_arbiter
    import array_alloc_pkg::*;
#(
    parameter int NReq               = DefNReq,
    parameter int NArrays            = DefNArrays,
    parameter int MemoryElementWidth = DefMemoryElementWidth
) (
    input  logic                          clock,
    input  logic                          reset,
    array_alloc_arbiter_if.slave          bus,
    output logic                          size_clear,
    output logic [MemoryElementWidth-1:0] size_clear_array,
    input  logic                          flush_req,
    output logic                          flush_done,
    output logic [MemoryElementWidth-1:0] allocs
);
    localparam int MW   = MemoryElementWidth;
    localparam int IdW  = (NReq > 1) ? $clog2(NReq) : 1;
    localparam int IdxW = (NArrays > 1) ? $clog2(NArrays) : 1;
    localparam int SpW  = $clog2(NArrays + 1);
    localparam logic [MW-1:0] NArr = MW'(NArrays);

    state_e          state_q;
    logic            rsp_valid_q;
    logic [IdW-1:0]  rsp_id_q;
    logic [MW-1:0]   rsp_array_q;
    rsp_err_e        rsp_error_q;
    logic            size_clear_q;
    logic [MW-1:0]   size_clear_array_q;
    logic            flush_done_q;
    logic [MW-1:0]   allocs_q;
    logic [MW-1:0]   flush_idx_q;
    logic [MW-1:0]   stack_q [NArrays];
    logic [SpW-1:0]  sp_q;
    logic [NArrays-1:0] inuse_q;

    logic [NReq-1:0] arb_req, grant;
    logic [IdW-1:0]  win_id;
    logic            win_op;
    logic [MW-1:0]   win_handle, top_handle;
    logic            free_ok;

    // Grants only in IDLE, and a pending flush blocks them outright.
    assign arb_req = bus.req_valid & {NReq{(state_q == ST_IDLE) && !flush_req}};

    rr_arbiter #(.NReq(NReq)) u_rr (
        .clock   (clock),
        .reset   (reset),
        .req     (arb_req),
        .advance (|grant),
        .grant   (grant)
    );

    always_comb begin
        win_id     = '0;
        win_op     = 1'b0;
        win_handle = '0;
        for (int i = 0; i < NReq; i++) begin
            if (grant[i]) begin
                win_id     = IdW'(i);
                win_op     = bus.req_op[i];
                win_handle = bus.req_array[i*MW +: MW];
            end
        end
        top_handle = stack_q[IdxW'(sp_q - 1'b1)];
        free_ok    = (win_handle < NArr) && inuse_q[IdxW'(win_handle)];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q            <= ST_IDLE;
            rsp_valid_q        <= 1'b0;
            rsp_id_q           <= '0;
            rsp_array_q        <= '0;
            rsp_error_q        <= ERR_OK;
            size_clear_q       <= 1'b0;
            size_clear_array_q <= '0;
            flush_done_q       <= 1'b0;
            allocs_q           <= '0;
            flush_idx_q        <= '0;
            sp_q               <= '0;
            inuse_q            <= '0;
        end else begin
            size_clear_q <= 1'b0;
            flush_done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (flush_req) begin
                        state_q     <= ST_FLUSH;
                        flush_idx_q <= '0;
                    end else if (|grant) begin
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_id_q    <= win_id;
                        rsp_array_q <= '0;
                        rsp_error_q <= ERR_OK;
                        if (win_op == OP_FREE) begin
                            if (free_ok) begin
                                stack_q[IdxW'(sp_q)]         <= win_handle;
                                sp_q                         <= sp_q + 1'b1;
                                inuse_q[IdxW'(win_handle)]   <= 1'b0;
                            end else begin
                                rsp_error_q <= ERR_BADFREE;
                            end
                        end else if (sp_q != '0) begin
                            sp_q                       <= sp_q - 1'b1;
                            inuse_q[IdxW'(top_handle)] <= 1'b1;
                            rsp_array_q                <= top_handle;
                            size_clear_q               <= 1'b1;
                            size_clear_array_q         <= top_handle;
                        end else if (allocs_q < NArr) begin
                            allocs_q                 <= allocs_q + 1'b1;
                            inuse_q[IdxW'(allocs_q)] <= 1'b1;
                            rsp_array_q              <= allocs_q;
                            size_clear_q             <= 1'b1;
                            size_clear_array_q       <= allocs_q;
                        end else begin
                            rsp_error_q <= ERR_EXHAUSTED;
                        end
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                ST_FLUSH: begin
                    if (flush_idx_q < allocs_q) begin
                        size_clear_q       <= 1'b1;
                        size_clear_array_q <= flush_idx_q;
                        flush_idx_q        <= flush_idx_q + 1'b1;
                    end else begin
                        allocs_q     <= '0;
                        sp_q         <= '0;
                        inuse_q      <= '0;
                        flush_done_q <= 1'b1;
                        state_q      <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready    = grant;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_id       = rsp_id_q;
    assign bus.rsp_array    = rsp_array_q;
    assign bus.rsp_error    = rsp_error_q;
    assign size_clear       = size_clear_q;
    assign size_clear_array = size_clear_array_q;
    assign flush_done       = flush_done_q;
    assign allocs           = allocs_q;

endmodule

// File: tb/tb_array_alloc_arbiter.sv
// Directed bench for array_alloc_arbiter with hand-computed expected responses.
module tb_array_alloc_arbiter;

    logic        clock;
    logic        reset;
    logic        size_clear;
    logic [11:0] size_clear_array;
    logic        flush_req;
    logic        flush_done;
    logic [11:0] allocs;

    int checks = 0;
    int errors = 0;

    array_alloc_arbiter_if #(.NReq(2), .MemoryElementWidth(12)) bus ();

    array_alloc_arbiter #(.NReq(2), .NArrays(4), .MemoryElementWidth(12)) dut (
        .clock            (clock),
        .reset            (reset),
        .bus              (bus),
        .size_clear       (size_clear),
        .size_clear_array (size_clear_array),
        .flush_req        (flush_req),
        .flush_done       (flush_done),
        .allocs           (allocs)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_array = '0;
        bus.rsp_ready = 1'b0;
        flush_req     = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    // One request from requester id with rsp_ready high; checks the grant and the response.
    task automatic xact(input string tag, input int id, input logic op, input logic [11:0] arr,
                        input logic [1:0] eerr, input logic [11:0] earr);
        int n;
        logic esc;
        @(negedge clock);
        bus.req_valid[id]          = 1'b1;
        bus.req_op[id]             = op;
        bus.req_array[id*12 +: 12] = arr;
        bus.rsp_ready              = 1'b1;
        #1;
        n = 0;
        while (!bus.req_ready[id] && n < 20) begin
            @(negedge clock);
            n++;
        end
        check_val({tag, ".gnt"}, 32'(bus.req_ready), 32'(1) << id);
        @(negedge clock);
        bus.req_valid[id] = 1'b0;
        esc = (op == 1'b0) && (eerr == 2'd0);
        check_val({tag, ".vld"}, 32'(bus.rsp_valid), 32'd1);
        check_val({tag, ".id"},  32'(bus.rsp_id), 32'(id));
        check_val({tag, ".arr"}, 32'(bus.rsp_array), 32'(earr));
        check_val({tag, ".err"}, 32'(bus.rsp_error), 32'(eerr));
        check_val({tag, ".sc"},  32'(size_clear), 32'(esc));
        if (esc) check_val({tag, ".sca"}, 32'(size_clear_array), 32'(earr));
    endtask

    logic [11:0] exp_h41 [5] = '{12'd0, 12'd1, 12'd2, 12'd3, 12'd0};
    logic [1:0]  exp_e41 [5] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1};

    initial begin
        int n;
        // Reset state
        reset         = 1'b1;
        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_array = '0;
        bus.rsp_ready = 1'b0;
        flush_req     = 1'b0;
        repeat (2) @(negedge clock);
        check_val("rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_val("rst.rsp_id",    32'(bus.rsp_id), 32'd0);
        check_val("rst.rsp_array", 32'(bus.rsp_array), 32'd0);
        check_val("rst.rsp_error", 32'(bus.rsp_error), 32'd0);
        check_val("rst.size_clear", 32'(size_clear), 32'd0);
        check_val("rst.flush_done", 32'(flush_done), 32'd0);
        check_val("rst.allocs",    32'(allocs), 32'd0);
        check_val("rst.req_ready", 32'(bus.req_ready), 32'd0);
        reset = 1'b0;

        // Two allocs from requester 0
        xact("a40.0", 0, 1'b0, 12'd0, 2'd0, 12'd0);
        xact("a40.1", 0, 1'b0, 12'd0, 2'd0, 12'd1);
        @(negedge clock);
        check_val("a40.allocs", 32'(allocs), 32'd2);

        // Both requesters contend every cycle
        do_reset();
        bus.rsp_ready = 1'b1;
        bus.req_valid = 2'b11;
        #1;
        for (int k = 0; k < 5; k++) begin
            check_val("rr.gnt", 32'(bus.req_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
            @(negedge clock);
            check_val("rr.id",  32'(bus.rsp_id), 32'(k % 2));
            check_val("rr.arr", 32'(bus.rsp_array), 32'(exp_h41[k]));
            check_val("rr.err", 32'(bus.rsp_error), 32'(exp_e41[k]));
            check_val("rr.sc",  32'(size_clear), (exp_e41[k] == 2'd0) ? 32'd1 : 32'd0);
            if (k == 4) bus.req_valid = '0;
            @(negedge clock);
        end
        check_val("rr.allocs", 32'(allocs), 32'd4);

        // LIFO reuse of freed handles
        do_reset();
        xact("l42.a0", 0, 1'b0, 12'd0, 2'd0, 12'd0);
        xact("l42.a1", 1, 1'b0, 12'd0, 2'd0, 12'd1);
        xact("l42.a2", 0, 1'b0, 12'd0, 2'd0, 12'd2);
        xact("l42.f1", 1, 1'b1, 12'd1, 2'd0, 12'd0);
        xact("l42.f2", 0, 1'b1, 12'd2, 2'd0, 12'd0);
        xact("l42.r2", 1, 1'b0, 12'd0, 2'd0, 12'd2);
        xact("l42.r1", 0, 1'b0, 12'd0, 2'd0, 12'd1);

        // Bad frees leave state alone
        xact("b43.f3",  0, 1'b1, 12'd3, 2'd2, 12'd0);
        xact("b43.f7",  1, 1'b1, 12'd7, 2'd2, 12'd0);
        xact("b43.f1",  0, 1'b1, 12'd1, 2'd0, 12'd0);
        xact("b43.f1x", 1, 1'b1, 12'd1, 2'd2, 12'd0);
        @(negedge clock);
        check_val("b43.allocs", 32'(allocs), 32'd3);

        // Response back-pressure: handle 1 sits on the stack
        bus.rsp_ready = 1'b0;
        bus.req_op    = 2'b00;
        bus.req_valid = 2'b10;
        #1;
        check_val("bp.gnt", 32'(bus.req_ready), 32'd2);
        @(negedge clock);
        bus.req_valid = 2'b11;
        #1;
        check_val("bp.first.sc",  32'(size_clear), 32'd1);
        check_val("bp.first.arr", 32'(bus.rsp_array), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check_val("bp.vld",   32'(bus.rsp_valid), 32'd1);
            check_val("bp.id",    32'(bus.rsp_id), 32'd1);
            check_val("bp.arr",   32'(bus.rsp_array), 32'd1);
            check_val("bp.err",   32'(bus.rsp_error), 32'd0);
            check_val("bp.sc",    32'(size_clear), 32'd0);
            check_val("bp.ready", 32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        bus.req_valid = '0;
        @(negedge clock);
        check_val("bp.done", 32'(bus.rsp_valid), 32'd0);

        // Flush after three allocs, contending with a request
        do_reset();
        xact("fl.a0", 0, 1'b0, 12'd0, 2'd0, 12'd0);
        xact("fl.a1", 1, 1'b0, 12'd0, 2'd0, 12'd1);
        xact("fl.a2", 0, 1'b0, 12'd0, 2'd0, 12'd2);
        @(negedge clock);
        flush_req     = 1'b1;
        bus.req_valid = 2'b01;
        #1;
        check_val("fl.nogrant", 32'(bus.req_ready), 32'd0);
        @(negedge clock);
        flush_req     = 1'b0;
        bus.req_valid = '0;
        n = 0;
        while (!size_clear && n < 10) begin
            @(negedge clock);
            n++;
        end
        check_val("fl.start", 32'(n < 10), 32'd1);
        for (int k = 0; k < 3; k++) begin
            check_val("fl.sc",   32'(size_clear), 32'd1);
            check_val("fl.sca",  32'(size_clear_array), 32'(k));
            check_val("fl.early_done", 32'(flush_done), 32'd0);
            @(negedge clock);
        end
        check_val("fl.done",     32'(flush_done), 32'd1);
        check_val("fl.sc_after", 32'(size_clear), 32'd0);
        check_val("fl.allocs",   32'(allocs), 32'd0);
        @(negedge clock);
        check_val("fl.done_pulse", 32'(flush_done), 32'd0);
        xact("fl.re0", 1, 1'b0, 12'd0, 2'd0, 12'd0);

        // Reset in the middle of a flush
        xact("rf.a1", 0, 1'b0, 12'd0, 2'd0, 12'd1);
        xact("rf.a2", 1, 1'b0, 12'd0, 2'd0, 12'd2);
        @(negedge clock);
        flush_req = 1'b1;
        @(negedge clock);
        flush_req = 1'b0;
        n = 0;
        while (!size_clear && n < 10) begin
            @(negedge clock);
            n++;
        end
        check_val("rf.start", 32'(n < 10), 32'd1);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            check_val("rf.no_done", 32'(flush_done), 32'd0);
            check_val("rf.no_sc",   32'(size_clear), 32'd0);
        end
        check_val("rf.allocs", 32'(allocs), 32'd0);
        xact("rf.re0", 0, 1'b0, 12'd0, 2'd0, 12'd0);

        @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/array_alloc_arbiter.md
ARRAY_ALLOC_ARBITER -- requirements
Module: array_alloc_arbiter

Interface
REQ-001 SHALL have parameter NReq, default 2, number of requesters sharing the heap allocator.
REQ-002 SHALL have parameter NArrays, default 4, maximum number of heap arrays.
REQ-003 SHALL have parameter MemoryElementWidth, default 12, width of array handles.
REQ-004 clock  input  1  driving clock; all state changes on posedge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  NReq  per-requester request valid.
REQ-007 req_op  input  NReq  per-requester op: 0 = alloc, 1 = free.
REQ-008 req_array  input  NReq*MemoryElementWidth  per-requester handle to free; ignored for alloc.
REQ-009 req_ready  output  NReq  one-hot grant; a transfer occurs when req_valid[i] && req_ready[i] at a posedge.
REQ-010 rsp_valid  output  1  response valid, held until rsp_ready.
REQ-011 rsp_ready  input  1  response consumed.
REQ-012 rsp_id  output  clog2(NReq) (min 1)  requester the response belongs to.
REQ-013 rsp_array  output  MemoryElementWidth  allocated handle, or 0 on error or free.
REQ-014 rsp_error  output  2  0 = OK, 1 = EXHAUSTED, 2 = BADFREE.
REQ-015 size_clear  output  1  one-cycle pulse: zero the size of array size_clear_array.
REQ-016 size_clear_array  output  MemoryElementWidth  handle whose size is to be zeroed.
REQ-017 flush_req  input  1  free every array and restart allocation from handle 0.
REQ-018 flush_done  output  1  one-cycle pulse when a flush completes.
REQ-019 allocs  output  MemoryElementWidth  high-water mark of handles ever issued since reset/flush.

Function
REQ-020 SHALL implement FSM states IDLE, RESP, FLUSH.
REQ-021 req_ready SHALL be combinational: nonzero only in IDLE with flush_req low, one-hot on the round-robin winner among asserted req_valid.
REQ-022 Round-robin SHALL start at requester 0 after reset; after each grant, priority moves to the requester after the granted one.
REQ-023 On a transfer, the op SHALL execute at that edge; state -> RESP; rsp_valid high from the next cycle (latency 1).
REQ-024 Alloc with a non-empty freed stack SHALL pop the top (LIFO) into rsp_array.
REQ-025 Alloc with an empty stack and allocs < NArrays SHALL return allocs, then increment allocs.
REQ-026 Alloc with an empty stack and allocs == NArrays SHALL return rsp_error = EXHAUSTED, rsp_array = 0, state unchanged.
REQ-027 Every successful alloc SHALL pulse size_clear with size_clear_array = the returned handle, in the same cycle rsp_valid first rises.
REQ-028 Free of a handle >= NArrays or not currently in use SHALL return BADFREE and change no state.
REQ-029 A valid free SHALL push the handle onto the freed stack, clear its in-use bit, and return OK with rsp_array = 0.
REQ-030 In RESP, outputs SHALL be held stable until rsp_valid && rsp_ready, then -> IDLE; no grant is issued while in RESP.
REQ-031 flush_req in IDLE SHALL win over any req_valid; state -> FLUSH.
REQ-032 FLUSH SHALL pulse size_clear for handles 0 .. allocs-1, one per cycle in ascending order, then clear the stack, the in-use bitmap and allocs; it SHALL pulse flush_done on the following cycle and return to IDLE.
REQ-033 FLUSH with allocs == 0 SHALL pulse flush_done one cycle after entry.
REQ-034 flush_req arriving in RESP SHALL be deferred until IDLE.
REQ-035 The freed stack depth SHALL be NArrays; overflow is impossible because only in-use handles are pushed.

Reset
REQ-036 Reset SHALL force IDLE, rsp_valid = 0, rsp_id = 0, rsp_array = 0, rsp_error = 0, size_clear = 0, flush_done = 0, allocs = 0, stack top = 0, in-use bitmap = 0, round-robin pointer = 0.
REQ-037 Reset asserted in RESP or FLUSH SHALL abort the operation with no size_clear or flush_done pulse.

Structure
REQ-038 Package array_alloc_pkg SHALL hold the op encoding, the rsp_error codes, the FSM state enum and default parameter values.
REQ-039 Round-robin selection SHALL be a sub-module rr_arbiter (NReq requests, one-hot grant, pointer advance enable).

Verification
REQ-040 Reset, then requester 0 allocs twice -> handles 0 and 1, size_clear for 0 then 1, allocs = 2.
REQ-041 Both requesters alloc every cycle, rsp_ready = 1 -> grants alternate 0,1,0,1; handles 0..3; fifth alloc -> EXHAUSTED, rsp_array = 0.
REQ-042 Alloc 0,1,2; free 1, then free 2; alloc -> 2; alloc -> 1 (LIFO).
REQ-043 Free 3 when never allocated -> BADFREE; free 7 (NArrays = 4) -> BADFREE; allocs unchanged.
REQ-044 rsp_ready held low 5 cycles -> rsp outputs stable, req_ready = 0 throughout; response completes on the cycle rsp_ready rises.
REQ-045 After 3 allocs, flush_req together with req_valid -> size_clear for 0,1,2, then flush_done, allocs = 0; next alloc -> 0. Reset mid-flush -> no flush_done.
